// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// General-purpose register file with two combinational read ports, one
// clocked write port, a per-register pending scoreboard and a same-cycle
// write-to-read bypass. Register 0 always reads zero and has no state.
//
// Parameters:
//   n     data width of each register
//   NREG  number of registers (2..2^AW), index 0 hardwired to zero
//   AW    address width
//
// Ports:
//   clk      clock, all state updates on posedge
//   Clr      asynchronous active-high clear of data, scoreboard and counter
//   RA, RB   read addresses for ports A and B
//   PA, PB   read data (combinational, includes write bypass)
//   BusyA/B  addressed register has an outstanding result (combinational)
//   WA, WD   write address and data
//   LE       write enable
//   Rsv      reserve enable, marks RsvA as pending
//   RsvA     register to reserve
//   PendCnt  registered count of pending registers
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int n    = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          Clr,
  input  logic [AW-1:0] RA,
  input  logic [AW-1:0] RB,
  output logic [n-1:0]  PA,
  output logic [n-1:0]  PB,
  output logic          BusyA,
  output logic          BusyB,
  input  logic [AW-1:0] WA,
  input  logic [n-1:0]  WD,
  input  logic          LE,
  input  logic          Rsv,
  input  logic [AW-1:0] RsvA,
  output logic [AW:0]   PendCnt
);

  localparam logic [AW:0] LP_NREG = (AW+1)'(NREG);

  // Entry 0 is reset and never written, so it folds away in synthesis.
  logic [n-1:0]    r_mem [NREG];
  logic [NREG-1:0] r_pend;
  logic [AW:0]     r_pendCnt;

  logic [NREG-1:0] w_pendNext;
  logic            w_raOk;
  logic            w_rbOk;
  logic            w_wrEn;
  logic            w_rsvEn;
  logic            w_inc;
  logic            w_dec;

  // Addresses of zero or beyond the array behave as hardwired-zero reads
  // and as no-ops for writes and reserves. LE/Rsv are masked while Clr is
  // high so nothing can sneak in on the clear edge.
  assign w_raOk  = (RA != '0)   && ({1'b0, RA}   < LP_NREG);
  assign w_rbOk  = (RB != '0)   && ({1'b0, RB}   < LP_NREG);
  assign w_wrEn  = LE  && !Clr && (WA != '0)   && ({1'b0, WA}   < LP_NREG);
  assign w_rsvEn = Rsv && !Clr && (RsvA != '0) && ({1'b0, RsvA} < LP_NREG);

  // Reserve is applied after write so that a same-register write+reserve
  // leaves the bit set: a new producer has already been issued.
  always_comb begin
    w_pendNext = r_pend;
    if (w_wrEn) begin
      w_pendNext[WA] = 1'b0;
    end
    if (w_rsvEn) begin
      w_pendNext[RsvA] = 1'b1;
    end
  end

  // Counter tracks the popcount of the pending bits incrementally. A write
  // only counts as a clear when the same-cycle reserve does not re-set it.
  assign w_inc = w_rsvEn && !r_pend[RsvA];
  assign w_dec = w_wrEn && r_pend[WA] && !(w_rsvEn && (RsvA == WA));

  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_pend    <= '0;
      r_pendCnt <= '0;
    end else begin
      if (w_wrEn) begin
        r_mem[WA] <= WD;
      end
      r_pend <= w_pendNext;
      if (w_inc && !w_dec) begin
        r_pendCnt <= r_pendCnt + (AW+1)'(1);
      end else if (w_dec && !w_inc) begin
        r_pendCnt <= r_pendCnt - (AW+1)'(1);
      end
    end
  end

  // Port A: a matching write this cycle is forwarded and the register is
  // reported not busy, since its result is arriving now.
  always_comb begin
    PA    = '0;
    BusyA = 1'b0;
    if (w_raOk) begin
      if (LE && (WA == RA) && !Clr) begin
        PA = WD;
      end else begin
        PA    = r_mem[RA];
        BusyA = r_pend[RA];
      end
    end
  end

  // Port B mirrors port A.
  always_comb begin
    PB    = '0;
    BusyB = 1'b0;
    if (w_rbOk) begin
      if (LE && (WA == RB) && !Clr) begin
        PB = WD;
      end else begin
        PB    = r_mem[RB];
        BusyB = r_pend[RB];
      end
    end
  end

  assign PendCnt = r_pendCnt;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the datapath. It has two combinational read ports and one clocked write port, and register 0 is hardwired to zero. A per-register pending scoreboard lets the pipeline mark a destination as "result outstanding" at issue and clear it at write-back. A same-cycle write-to-read bypass means a dependent instruction can read the value on the write-back cycle without waiting an extra clock.

## Interface
Parameters:
- n, 32, data width of each register
- NREG, 16, number of registers (2..2^AW); register 0 always reads zero
- AW, 4, address width

Ports:
- clk  in  1  clock; all state updates on posedge
- Clr  in  1  asynchronous, active-high reset; clears all registers, scoreboard and counter
- RA  in  AW  read address, port A
- RB  in  AW  read address, port B
- PA  out  n  read data, port A (combinational)
- PB  out  n  read data, port B (combinational)
- BusyA  out  1  addressed register A has an outstanding result (combinational)
- BusyB  out  1  addressed register B has an outstanding result (combinational)
- WA  in  AW  write address
- WD  in  n  write data
- LE  in  1  write enable; writes WD to WA at posedge clk
- Rsv  in  1  reserve enable; sets the pending bit of RsvA at posedge clk
- RsvA  in  AW  register to reserve
- PendCnt  out  AW+1  number of registers currently pending (registered)

## Operation
- Register array `R[1..NREG-1]`, each n bits, plus pending bits `P[1..NREG-1]`. There is no storage for index 0.
- Addresses >= NREG: reads return 0 and Busy 0; writes and reserves are ignored.
- Read port A (port B is identical):
  - RA==0 gives PA=0 and BusyA=0.
  - Otherwise, if LE and WA==RA and Clr==0: PA=WD (bypass) and BusyA=0.
  - Otherwise PA=R[RA] and BusyA=P[RA].
- Write: on posedge with LE and WA!=0, R[WA]<=WD and P[WA]<=0. Writing a register that is not pending is legal and only updates data.
- Reserve: on posedge with Rsv and RsvA!=0, P[RsvA]<=1.
- Simultaneous write and reserve:
  - Same register: reserve wins. Data updates and P stays 1, because a new producer has been issued.
  - Different registers: both take effect.
- PendCnt tracks the population count of P. It increments when a reserve sets a bit that was 0. It decrements when a write clears a bit that was 1. Both events in the same cycle on different registers leave it unchanged. Re-reserving an already pending register does not change it.
- Clr=1, asynchronous and immediate:
  - All R and P go to 0 and PendCnt goes to 0.
  - The bypass is suppressed, so PA=PB=0 and BusyA=BusyB=0 while Clr is high.
  - LE and Rsv are ignored for as long as Clr is high.
- Reset mid-operation discards all outstanding reservations. The pipeline is flushed alongside.

## Timing
- Read latency is 0 cycles, combinational from RA/RB, LE, WA and WD.
- A write is visible through storage from the cycle after the posedge, and through the bypass in the same cycle.
- A reserve is visible on Busy from the cycle after the posedge.
- PendCnt updates on the same posedge as the P change.
- Reset values: PA=0, PB=0, BusyA=0, BusyB=0, PendCnt=0.
- Clr deassertion is synchronous to the design clock by the system. The first state change is allowed on the first posedge with Clr=0.

## Test plan
- Reset, then read all addresses. Then write R5=0xDEADBEEF with LE=1 and read RA=5 the next cycle. Required: PA=0 before the write and 0xDEADBEEF after.
- Write WA=0, WD=0xFFFFFFFF, then read RA=0 and RB=0. Required: PA=PB=0 both during the write cycle (no bypass) and after it.
- Drive LE=1, WA=7, WD=0x1234 with RA=7 in the same cycle, where R7 holds 0x5. Required: PA=0x1234 that cycle, and BusyA=0 even if P7=1.
- Reserve R3, then R9. Required: PendCnt=1, then 2, with BusyA=1 on RA=3. Then in one cycle write R3 and reserve R3. Required: P3 stays 1, PendCnt=2, R3 updated. Then write R9. Required: PendCnt=1.
- Reserve R4 with LE on WA=4 in the same cycle when P4=0. Required: P4=1 and PendCnt+1. Re-reserve R4. Required: PendCnt unchanged.
- With R2=0xAA, P2=1 and PendCnt=1, pulse Clr mid-cycle while LE=1, WA=2. Required: PA (RA=2)=0, BusyA=0 and PendCnt=0 immediately, and no write occurs at the next posedge while Clr is high.
